// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by uart_receiver and uart_transmitter.
package uart_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] START  = 3'd1;
    localparam logic [STATE_W-1:0] DATA   = 3'd2;
    localparam logic [STATE_W-1:0] STOP   = 3'd3;
    localparam logic [STATE_W-1:0] PARITY = 3'd4;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

    // Counter width for a modulo-n counter, never narrower than min_w.
    function automatic int unsigned cnt_width(input int unsigned n, input int unsigned min_w);
        int unsigned w;
        w = $clog2(n);
        return (w < min_w) ? min_w : w;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; both stages reset to 1
// so an idle-high line does not produce a spurious low after reset.
module uart_sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= '1;
            o_q    <= '1;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 16x oversampled, LSB first, mid-bit sampling.
// Define UART_RX_PARITY_EN to add a parity bit and o_parity_error.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned STP_BITS_TICKS = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD     = 1'b0
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_bd_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_error,
`endif
    output logic                 o_rx_busy
);

    localparam int unsigned TW = cnt_width(STP_BITS_TICKS, 4);
    localparam int unsigned BW = cnt_width(DATA_BITS, 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(MID_TICK);
    localparam logic [TW-1:0] TICK_BIT  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_STOP = TW'(STP_BITS_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_sync;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 done_d;
    logic                 ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 perr_d;
`endif

    uart_sync_2ff #(
        .WIDTH (1)
    ) u_rx_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (i_rx),
        .o_q       (rx_sync)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = o_data;
        ferr_d  = o_frame_error;
        done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = o_parity_error;
`endif
        case (state_q)
            IDLE: begin
                // Start-bit detection does not wait for a tick.
                if (!rx_sync) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (i_bd_tick) begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_sync) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (i_bd_tick) begin
                    if (tick_q == TICK_BIT) begin
                        shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_bd_tick) begin
                    if (tick_q == TICK_BIT) begin
                        par_bit_d = rx_sync;
                        tick_d    = '0;
                        state_d   = STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (i_bd_tick) begin
                    if (tick_q == TICK_STOP) begin
                        data_d  = shift_q;
                        ferr_d  = ~rx_sync;
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^shift_q) ^ par_bit_q ^ PARITY_ODD;
`endif
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            o_data        <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
            o_rx_busy     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            o_data        <= data_d;
            o_rx_done     <= done_d;
            o_frame_error <= ferr_d;
            o_rx_busy     <= (state_d != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            par_bit_q      <= 1'b0;
            o_parity_error <= 1'b0;
        end else begin
            par_bit_q      <= par_bit_d;
            o_parity_error <= perr_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus random frames
// compared against a frame-level reference model.
module tb_uart_receiver;

    localparam int unsigned DW = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_bd_tick;
    logic          i_rx;
    logic [DW-1:0] o_data;
    logic          o_rx_done;
    logic          o_frame_error;
    logic          o_rx_busy;
    logic          perr_w;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int dbl_cnt  = 0;

    // Entries are {parity_error, frame_error, data}.
    logic [DW+1:0] got_q[$];
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] exp_data = '0;
    logic          exp_ferr = 1'b0;
    logic          exp_perr = 1'b0;

    uart_receiver #(
        .DATA_BITS      (DW),
        .STP_BITS_TICKS (16)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_bd_tick      (i_bd_tick),
        .i_rx           (i_rx),
        .o_data         (o_data),
        .o_rx_done      (o_rx_done),
        .o_frame_error  (o_frame_error),
`ifdef UART_RX_PARITY_EN
        .o_parity_error (perr_w),
`endif
        .o_rx_busy      (o_rx_busy)
    );

`ifndef UART_RX_PARITY_EN
    assign perr_w = 1'b0;
`endif

    initial forever #5 i_clk = ~i_clk;

    // Capture every done pulse and flag any pulse longer than one cycle.
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_rx_done) begin
                done_cnt++;
                got_q.push_back({perr_w, o_frame_error, o_data});
                if (done_prev) dbl_cnt++;
            end
            done_prev = o_rx_done;
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // One oversampling period: tick high for one clock out of four.
    task automatic tick_cycle();
        @(negedge i_clk) i_bd_tick = 1'b1;
        @(negedge i_clk) i_bd_tick = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic drive(input logic level, input int n);
        i_rx = level;
        repeat (n) tick_cycle();
    endtask

    // Sends one frame; a bad stop bit is low through its midpoint, then the line idles a bit time.
    task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok, input bit par_flip,
                              input int pause_bit);
        drive(1'b0, 16);
        for (int i = 0; i < int'(DW); i++) begin
            if (i == pause_bit) begin
                i_rx = d[i];
                repeat (5) tick_cycle();
                repeat (50) @(negedge i_clk);
                check("busy_paused", 32'(o_rx_busy), 32'd1);
                check("done_paused", done_cnt, exp_done);
                repeat (11) tick_cycle();
            end else begin
                drive(d[i], 16);
            end
        end
        if (PAR_EN) drive((^d) ^ par_flip, 16);
        if (stop_ok) begin
            drive(1'b1, 16);
        end else begin
            drive(1'b0, 9);
            drive(1'b1, 7 + 16);
        end
        exp_done++;
        exp_data = d;
        exp_ferr = !stop_ok;
        exp_perr = PAR_EN & par_flip;
        exp_q.push_back({exp_perr, exp_ferr, d});
    endtask

    task automatic verify(input string name);
        logic [DW+1:0] e;
        logic [DW+1:0] g;
        check({name, "_done_cnt"}, done_cnt, exp_done);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
            check({name, "_frame"}, 32'(g), 32'(e));
        end
        check({name, "_extra_done"}, got_q.size(), 0);
        check({name, "_data"}, 32'(o_data), 32'(exp_data));
        check({name, "_ferr"}, 32'(o_frame_error), 32'(exp_ferr));
        check({name, "_perr"}, 32'(perr_w), 32'(exp_perr));
        check({name, "_busy"}, 32'(o_rx_busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        bit            rok;
        bit            rpf;

        i_reset_n = 1'b0;
        i_rx      = 1'b1;
        i_bd_tick = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_done", 32'(o_rx_done), 32'd0);
        check("rst_ferr", 32'(o_frame_error), 32'd0);
        check("rst_busy", 32'(o_rx_busy), 32'd0);
        i_reset_n = 1'b1;
        drive(1'b1, 16);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        verify("a5");

        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        verify("b2b");

        // Start glitch shorter than half a bit.
        drive(1'b0, 4);
        drive(1'b1, 32);
        verify("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        verify("bad_stop");
        send_frame(8'h11, 1'b1, 1'b0, -1);
        verify("good_after_bad");

        // Break: line low past the stop-bit sample point.
        drive(1'b0, 153);
        drive(1'b1, 32);
        exp_done++;
        exp_data = '0;
        exp_ferr = 1'b1;
        exp_perr = 1'b0;
        exp_q.push_back({1'b0, 1'b1, {DW{1'b0}}});
        verify("break");

        send_frame(8'h11, 1'b1, 1'b0, -1);
        verify("pre_reset");

        // Reset during data bit 4.
        drive(1'b0, 16);
        for (int i = 0; i < 4; i++) drive(1'(8'h96 >> i), 16);
        drive(1'b1, 5);
        @(negedge i_clk) i_reset_n = 1'b0;
        #1;
        check("midrst_data", 32'(o_data), 32'd0);
        check("midrst_done", 32'(o_rx_done), 32'd0);
        check("midrst_ferr", 32'(o_frame_error), 32'd0);
        check("midrst_busy", 32'(o_rx_busy), 32'd0);
        exp_data = '0;
        exp_ferr = 1'b0;
        exp_perr = 1'b0;
        i_rx = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        drive(1'b1, 16);
        verify("midrst_nodone");
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        verify("after_rst");

        send_frame(8'hC3, 1'b1, 1'b0, 3);
        verify("tick_pause");

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b1, -1);
            verify("parity_bad");
        end

        for (int n = 0; n < 8; n++) begin
            rd  = DW'($urandom_range(0, 255));
            rok = ($urandom_range(0, 3) != 0);
            rpf = PAR_EN & 1'($urandom_range(0, 1));
            send_frame(rd, rok, rpf, -1);
            verify("random");
        end

        check("done_width", dbl_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
